// File: rtl/psxddr_pkg.sv
// Shared types and constants for the PSX GPU DDR-side Avalon responder.
// Command-size codes are common with the GPU memory bridge.
package psxddr_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;

    localparam logic [1:0] CMD_8BYTE  = 2'd0;
    localparam logic [1:0] CMD_32BYTE = 2'd1;
    localparam logic [1:0] CMD_4BYTE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR_BURST = 2'd1,
        S_RD_BURST = 2'd2
    } resp_state_t;

    // A zero burst length on the bus means a single beat.
    function automatic logic [2:0] burst_count(input logic [2:0] len);
        return (len == 3'd0) ? 3'd1 : len;
    endfunction

endpackage

// File: rtl/psxddr_rd_pipe.sv
// Read-return pipeline: LATENCY-deep valid+data shift register, synchronous flush.
// Latency LATENCY cycles; no backpressure, one beat in and out per cycle; output data holds between beats.
module psxddr_rd_pipe #(
    parameter int LATENCY = 2,
    parameter int DATA_W  = 64
) (
    input  logic              clk_i,
    input  logic              flush_i,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] dat_o
);

    logic              vld_q [LATENCY];
    logic [DATA_W-1:0] dat_q [LATENCY];

    // Data only advances behind a valid beat, so the last stage holds the previous beat.
    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            for (int k = 0; k < LATENCY; k++) begin
                vld_q[k] <= 1'b0;
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= vld_i;
            if (vld_i) begin
                dat_q[0] <= dat_i;
            end
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
    end

    assign vld_o = vld_q[LATENCY-1];
    assign dat_o = dat_q[LATENCY-1];

endmodule

// File: rtl/psxddr_avalon_responder.sv
// Avalon-MM DDR stand-in for the PSX GPU bridge: RAM-backed, READ_LATENCY read return, periodic wait-request stalls.
// Define PSXDDR_RESP_BURST_EN for Avalon burst handling; otherwise every beat carries its own address.
module psxddr_avalon_responder
    import psxddr_pkg::*;
#(
    parameter int DEPTH        = 131072,
    parameter int READ_LATENCY = 2,
    parameter int STALL_PERIOD = 0
) (
    input  logic              i_clk,
    input  logic              i_nRst,
    input  logic [ADDR_W-1:0] i_targetAddr,
    input  logic [2:0]        i_burstLength,
    input  logic              i_readEnableMem,
    input  logic              i_writeEnableMem,
    input  logic [DATA_W-1:0] i_dataMem,
    input  logic [BE_W-1:0]   i_byteEnableMem,
    output logic              o_busyMem,
    output logic              o_dataValidMem,
    output logic [DATA_W-1:0] o_dataMem
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

    typedef logic [IDX_W-1:0] idx_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    resp_state_t      state_q, state_d;
    idx_t             base_q, base_d;
    logic [2:0]       beat_q, beat_d;
    logic [2:0]       len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic stall;
    logic acc_rd, acc_wr;
    logic rd_issue, wr_en;
    idx_t rd_addr, wr_addr;

    always_comb begin
        stall = 1'b0;
        cnt_d = '0;
        if (STALL_PERIOD != 0) begin
            stall = (cnt_q == CNT_LAST);
            cnt_d = stall ? '0 : cnt_q + 1'b1;
        end
    end

    // Wait-request never looks at the request inputs of the same cycle.
    assign o_busyMem = stall | (state_q == S_RD_BURST);
    assign acc_rd    = i_readEnableMem  & ~o_busyMem;
    assign acc_wr    = i_writeEnableMem & ~o_busyMem;

    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        beat_d  = beat_q;
        len_d   = len_q;
`ifdef PSXDDR_RESP_BURST_EN
        case (state_q)
            S_IDLE: begin
                if ((acc_wr || acc_rd) && (burst_count(i_burstLength) > 3'd1)) begin
                    state_d = acc_wr ? S_WR_BURST : S_RD_BURST;
                    base_d  = i_targetAddr[IDX_W-1:0];
                    len_d   = burst_count(i_burstLength);
                    beat_d  = 3'd1;
                end
            end
            S_WR_BURST: begin
                if (acc_wr) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == len_q - 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RD_BURST: begin
                beat_d = beat_q + 3'd1;
                if (beat_q == len_q - 3'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`else
        state_d = S_IDLE;
`endif
    end

    // A write wins over a simultaneous read; the read is dropped silently.
    always_comb begin
        rd_issue = acc_rd & ~acc_wr;
        rd_addr  = i_targetAddr[IDX_W-1:0];
        wr_en    = acc_wr;
        wr_addr  = i_targetAddr[IDX_W-1:0];
`ifdef PSXDDR_RESP_BURST_EN
        if (state_q == S_RD_BURST) begin
            rd_issue = 1'b1;
            rd_addr  = base_q + idx_t'(beat_q);
        end
        if (state_q == S_WR_BURST) begin
            rd_issue = 1'b0;
            wr_addr  = base_q + idx_t'(beat_q);
        end
`endif
    end

`ifndef PSXDDR_RESP_BURST_EN
    logic unused_burst;
    assign unused_burst = ^i_burstLength;
`endif

    always_ff @(posedge i_clk) begin
        if (wr_en && i_nRst) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_byteEnableMem[b]) begin
                    mem_q[wr_addr][8*b +: 8] <= i_dataMem[8*b +: 8];
                end
            end
        end
    end

    psxddr_rd_pipe #(
        .LATENCY (READ_LATENCY),
        .DATA_W  (DATA_W)
    ) u_rd_pipe (
        .clk_i   (i_clk),
        .flush_i (~i_nRst),
        .vld_i   (rd_issue),
        .dat_i   (mem_q[rd_addr]),
        .vld_o   (o_dataValidMem),
        .dat_o   (o_dataMem)
    );

endmodule
